// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side types: data/address width, reset PC
// and the fetch sequencer state encoding.
package fetch_unit_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer feeding the 16-bit IR.
// Ports: clock/reset(n), stall, branch_*, mem req/ready/rvalid, ir_*, busy.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_W = fetch_unit_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = fetch_unit_pkg::RESET_PC,
  parameter int unsigned PC_INC = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [DATA_W-1:0] branch_target,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_write,
  output logic [DATA_W-1:0] ir_data,
  output logic [DATA_W-1:0] ir_pc,
  output logic              busy
);

  fetch_state_e      state;
  logic [DATA_W-1:0] fetch_pc;
  logic [DATA_W-1:0] held_instr;
  logic [DATA_W-1:0] held_pc;
  logic              squash;
  logic [DATA_W-1:0] pc_next;

  // wraps naturally at 2^DATA_W
  assign pc_next = fetch_pc + DATA_W'(PC_INC);

  // gated by reset so no request leaks out while held in reset
  assign mem_req  = reset && (state == FETCH_REQ);
  assign mem_addr = fetch_pc;
  assign busy     = (state != FETCH_REQ);

  // a branch in HOLD drops the held word
  assign ir_write = (state == FETCH_HOLD)
                  && !stall && !branch_valid;
  assign ir_data  = held_instr;
  assign ir_pc    = held_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= FETCH_REQ;
      fetch_pc   <= RESET_PC;
      squash     <= 1'b0;
      held_instr <= '0;
      held_pc    <= '0;
    end else begin
      unique case (state)
        FETCH_REQ: begin
          if (branch_valid)
            fetch_pc <= branch_target;
          if (mem_ready) begin
            state <= FETCH_WAIT;
            // old address is in flight; its data is stale
            if (branch_valid)
              squash <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (branch_valid) begin
            fetch_pc <= branch_target;
            // same-cycle data is discarded, nothing left to kill
            squash   <= !mem_rvalid;
            if (mem_rvalid)
              state <= FETCH_REQ;
          end else if (mem_rvalid) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= FETCH_REQ;
            end else begin
              held_instr <= mem_rdata;
              held_pc    <= fetch_pc;
              state      <= FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (branch_valid) begin
            fetch_pc <= branch_target;
            state    <= FETCH_REQ;
          end else if (!stall) begin
            fetch_pc <= pc_next;
            state    <= FETCH_REQ;
          end
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the
// expected IR writes, a monitor pops them on each ir_write.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        ir_write;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  logic       ready_en;
  int         extra;
  logic       pend;
  int         cnt;
  logic [15:0] paddr;

  fetch_unit dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .ir_write(ir_write),
    .ir_data(ir_data),
    .ir_pc(ir_pc),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] rd(input logic [15:0] a);
    case (a)
      16'h0000: rd = 16'h1234;
      16'h0001: rd = 16'h5678;
      16'h0002: rd = 16'hABCD;
      16'h0003: rd = 16'hDEAD;
      16'h0010: rd = 16'h7777;
      16'h0040: rd = 16'h4444;
      16'h0041: rd = 16'h9999;
      16'hFFFF: rd = 16'h0BEE;
      default:  rd = a ^ 16'hA5A5;
    endcase
  endfunction

  // memory model: data arrives extra+1 cycles after accept;
  // deliberately not reset so a stale rvalid can follow reset
  assign mem_ready  = ready_en;
  assign mem_rvalid = pend && (cnt == 0);
  assign mem_rdata  = rd(paddr);

  initial begin
    pend  = 1'b0;
    cnt   = 0;
    paddr = '0;
  end

  always @(posedge clock) begin
    if (mem_req && mem_ready) begin
      pend  <= 1'b1;
      cnt   <= extra;
      paddr <= mem_addr;
    end else if (pend && cnt == 0) begin
      pend <= 1'b0;
    end else if (pend) begin
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // monitor
  always begin
    @(negedge clock);
    #2;
    if (reset && ir_write) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ir_write unexpected: data %h pc %h",
                 ir_data, ir_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ir_data !== e.data || ir_pc !== e.pc) begin
          n_fail++;
          $display("FAIL ir: got %h@%h expected %h@%h",
                   ir_data, ir_pc, e.data, e.pc);
        end
      end
    end
  end

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    ready_en      = 1'b1;
    extra         = 0;

    // reset
    repeat (3) begin
      tick();
      chk("rst ir_write", 32'(ir_write), 32'd0);
      chk("rst ir_data", 32'(ir_data), 32'h0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("first req", 32'(mem_req), 32'd1);
    chk("first addr", 32'(mem_addr), 32'h0);

    // two back-to-back fetches, 3 cycles each
    sb.push_back('{16'h1234, 16'h0000});
    sb.push_back('{16'h5678, 16'h0001});
    repeat (6) tick();
    chk("seq drained", 32'(sb.size()), 32'd0);
    chk("seq addr", 32'(mem_addr), 32'h2);
    chk("seq req", 32'(mem_req), 32'd1);

    // stall in HOLD
    stall = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall ir_write", 32'(ir_write), 32'd0);
      chk("stall ir_data", 32'(ir_data), 32'hABCD);
      chk("stall ir_pc", 32'(ir_pc), 32'h2);
      chk("stall req", 32'(mem_req), 32'd0);
      chk("stall busy", 32'(busy), 32'd1);
      if (i < 3) tick();
    end
    sb.push_back('{16'hABCD, 16'h0002});
    stall = 1'b0;
    tick();
    chk("unstall addr", 32'(mem_addr), 32'h3);
    chk("unstall req", 32'(mem_req), 32'd1);

    // branch in WAIT, data arrives a cycle later
    extra = 1;
    tick();
    branch_valid  = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_valid = 1'b0;
    chk("squash busy", 32'(busy), 32'd1);
    chk("squash rvalid", 32'(mem_rvalid), 32'd1);
    tick();
    chk("br addr", 32'(mem_addr), 32'h40);
    chk("br req", 32'(mem_req), 32'd1);
    extra = 0;
    sb.push_back('{16'h4444, 16'h0040});
    repeat (3) tick();
    chk("br next addr", 32'(mem_addr), 32'h41);

    // branch in REQ as request is accepted, to FFFF
    branch_valid  = 1'b1;
    branch_target = 16'hFFFF;
    tick();
    branch_valid = 1'b0;
    chk("req-br busy", 32'(busy), 32'd1);
    tick();
    chk("wrap addr", 32'(mem_addr), 32'hFFFF);
    chk("wrap req", 32'(mem_req), 32'd1);
    sb.push_back('{16'h0BEE, 16'hFFFF});
    repeat (3) tick();
    chk("wrap next", 32'(mem_addr), 32'h0);

    // branch in HOLD drops the held word
    repeat (2) tick();
    chk("hold data", 32'(ir_data), 32'h1234);
    branch_valid  = 1'b1;
    branch_target = 16'h0010;
    #1;
    chk("hold-br ir_write", 32'(ir_write), 32'd0);
    tick();
    branch_valid = 1'b0;
    chk("hold-br addr", 32'(mem_addr), 32'h10);
    chk("hold-br busy", 32'(busy), 32'd0);

    // reset while WAIT, stale rvalid afterwards
    extra = 2;
    tick();
    chk("pre-rst busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid-rst req", 32'(mem_req), 32'd0);
    chk("mid-rst addr", 32'(mem_addr), 32'h0);
    chk("mid-rst ir_write", 32'(ir_write), 32'd0);
    chk("mid-rst ir_data", 32'(ir_data), 32'h0);
    chk("mid-rst ir_pc", 32'(ir_pc), 32'h0);
    chk("mid-rst busy", 32'(busy), 32'd0);
    tick();
    reset    = 1'b1;
    ready_en = 1'b0;
    #1;
    chk("post-rst req", 32'(mem_req), 32'd1);
    chk("post-rst addr", 32'(mem_addr), 32'h0);
    tick();
    chk("late rvalid", 32'(mem_rvalid), 32'd1);
    tick();
    chk("late ignored busy", 32'(busy), 32'd0);
    chk("late ignored req", 32'(mem_req), 32'd1);
    ready_en = 1'b1;
    extra    = 0;
    sb.push_back('{16'h1234, 16'h0000});
    repeat (3) tick();
    chk("final addr", 32'(mem_addr), 32'h1);
    chk("final drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
